// File: rtl/series_accumulator.sv
// Arithmetic-series engine: accumulates terms (or squared terms) of first, first+step, ... <= last,
// one term per clock, behind a start/busy/done/ack handshake.
module series_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ack,
    input  logic              mode,
    input  logic [DATA_W-1:0] first,
    input  logic [DATA_W-1:0] last,
    input  logic [DATA_W-1:0] step,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic [DATA_W:0]   terms,
    output logic              overflow
);

    localparam int PW = 2 * DATA_W;
    // Adder is wide enough for both the accumulator and a full square, so no carry is ever lost.
    localparam int SW = (PW > ACC_W) ? PW + 1 : ACC_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] step_q, step_d;
    logic [DATA_W-1:0] cur_q, cur_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic [DATA_W:0]   terms_q, terms_d;
    logic              overflow_q, overflow_d;

    logic [PW-1:0]     sq;
    logic [SW-1:0]     term, sum;
    logic              add_ovf;
    logic [DATA_W:0]   nxt, cnt_inc;
    logic              stop;

    always_comb begin
        sq      = PW'(cur_q) * PW'(cur_q);
        term    = mode_q ? SW'(sq) : SW'(cur_q);
        sum     = SW'(acc_q) + term;
        add_ovf = |sum[SW-1:ACC_W];
        cnt_inc = cnt_q + (DATA_W+1)'(1);
        // Carry into bit DATA_W takes part in the compare, so cur never wraps.
        nxt     = {1'b0, cur_q} + {1'b0, step_q};
        stop    = nxt > {1'b0, last_q};
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        last_d     = last_q;
        step_d     = step_q;
        cur_d      = cur_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        terms_d    = terms_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mode_d = mode;
                    last_d = last;
                    step_d = (step == '0) ? DATA_W'(1) : step;
                    cur_d  = first;
                    acc_d  = '0;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                    if (first > last) begin
                        state_d    = DONE;
                        result_d   = '0;
                        terms_d    = '0;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
                end else if (state_q == DONE && ack) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = sum[ACC_W-1:0];
                cnt_d = cnt_inc;
                ovf_d = ovf_q | add_ovf;
                if (stop) begin
                    state_d    = DONE;
                    result_d   = sum[ACC_W-1:0];
                    terms_d    = cnt_inc;
                    overflow_d = ovf_q | add_ovf;
                end else begin
                    cur_d = nxt[DATA_W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= 1'b0;
            last_q     <= '0;
            step_q     <= '0;
            cur_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            terms_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            last_q     <= last_d;
            step_q     <= step_d;
            cur_q      <= cur_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            terms_q    <= terms_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign terms    = terms_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_series_accumulator.sv
// Directed bench for series_accumulator: default (ACC_W=24) instance plus an ACC_W=12
// instance sharing the same stimulus for the modulo/overflow cases.
module tb_series_accumulator;

    logic        clk = 1'b0;
    logic        rst, start, ack, mode;
    logic [7:0]  first, last, step;
    logic        busy, done, overflow;
    logic [23:0] result;
    logic [8:0]  terms;
    logic        busy12, done12, overflow12;
    logic [11:0] result12;
    logic [8:0]  terms12;

    int n_chk  = 0;
    int n_fail = 0;
    int excl_viol = 0;
    int nb;

    always #5 clk = ~clk;

    series_accumulator #(.DATA_W(8), .ACC_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .ack(ack), .mode(mode),
        .first(first), .last(last), .step(step),
        .busy(busy), .done(done), .result(result), .terms(terms), .overflow(overflow)
    );

    series_accumulator #(.DATA_W(8), .ACC_W(12)) dut12 (
        .clk(clk), .rst(rst), .start(start), .ack(ack), .mode(mode),
        .first(first), .last(last), .step(step),
        .busy(busy12), .done(done12), .result(result12), .terms(terms12), .overflow(overflow12)
    );

    always @(negedge clk) if (busy && done) excl_viol++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_start(input logic m, input logic [7:0] f, input logic [7:0] l, input logic [7:0] s);
        mode = m; first = f; last = l; step = s; start = 1'b1;
        tick();
        start = 1'b0;
        mode = ~m; first = 8'hA5; last = 8'h5A; step = 8'h33;
    endtask

    // Counts remaining busy cycles until the run leaves RUN; bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            tick();
        end
        chk("run_timeout", 32'(n < 1000), 1);
    endtask

    task automatic run(input logic m, input logic [7:0] f, input logic [7:0] l, input logic [7:0] s,
                       output int n);
        run_start(m, f, l, s);
        wait_done(n);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ack = 1'b0; mode = 1'b0;
        first = '0; last = '0; step = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_result", 32'(result), 0);
        chk("reset_terms", 32'(terms), 0);
        chk("reset_ovf", 32'(overflow), 0);

        run(1'b0, 8'd1, 8'd100, 8'd1, nb);
        chk("sum100_busy_cycles", 32'(nb), 100);
        chk("sum100_done", 32'(done), 1);
        chk("sum100_result", 32'(result), 5050);
        chk("sum100_terms", 32'(terms), 100);
        chk("sum100_ovf", 32'(overflow), 0);
        chk("acc12_result", 32'(result12), 954);
        chk("acc12_ovf", 32'(overflow12), 1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("ack_done_low", 32'(done), 0);
        chk("ack_busy_low", 32'(busy), 0);
        chk("ack_result_held", 32'(result), 5050);
        tick();
        chk("idle_result_held", 32'(result), 5050);

        run(1'b0, 8'd1, 8'd10, 8'd1, nb);
        chk("sum10_result", 32'(result), 55);
        chk("acc12_sum10_result", 32'(result12), 55);
        chk("acc12_sum10_ovf", 32'(overflow12), 0);

        run(1'b1, 8'd1, 8'd10, 8'd1, nb);
        chk("sq10_result", 32'(result), 385);
        chk("sq10_terms", 32'(terms), 10);
        run(1'b1, 8'd1, 8'd10, 8'd0, nb);
        chk("sq10_step0_result", 32'(result), 385);
        chk("sq10_step0_terms", 32'(terms), 10);

        run(1'b0, 8'd2, 8'd20, 8'd3, nb);
        chk("step3_result", 32'(result), 77);
        chk("step3_terms", 32'(terms), 7);

        run(1'b0, 8'd250, 8'd255, 8'd10, nb);
        chk("nowrap_busy_cycles", 32'(nb), 1);
        chk("nowrap_result", 32'(result), 250);
        chk("nowrap_terms", 32'(terms), 1);

        run(1'b0, 8'd9, 8'd3, 8'd1, nb);
        chk("empty_busy_cycles", 32'(nb), 0);
        chk("empty_done", 32'(done), 1);
        chk("empty_result", 32'(result), 0);
        chk("empty_terms", 32'(terms), 0);

        run(1'b1, 8'd0, 8'd255, 8'd1, nb);
        chk("sq255_busy_cycles", 32'(nb), 256);
        chk("sq255_result", 32'(result), 5559680);
        chk("sq255_terms", 32'(terms), 256);
        chk("sq255_ovf", 32'(overflow), 0);

        // start in RUN must be ignored
        run_start(1'b0, 8'd1, 8'd100, 8'd1);
        repeat (10) tick();
        mode = 1'b1; first = 8'd1; last = 8'd5; step = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(nb);
        chk("midstart_busy_left", 32'(nb), 89);
        chk("midstart_result", 32'(result), 5050);
        chk("midstart_terms", 32'(terms), 100);

        // start+ack together in DONE: start wins, back-to-back
        mode = 1'b0; first = 8'd1; last = 8'd3; step = 8'd1; start = 1'b1; ack = 1'b1;
        tick();
        start = 1'b0; ack = 1'b0;
        chk("startack_busy", 32'(busy), 1);
        chk("startack_done", 32'(done), 0);
        wait_done(nb);
        chk("startack_busy_cycles", 32'(nb), 3);
        chk("startack_result", 32'(result), 6);
        chk("startack_terms", 32'(terms), 3);

        // reset at RUN cycle 40, with a simultaneous start that must be dropped
        run_start(1'b0, 8'd1, 8'd100, 8'd1);
        repeat (39) tick();
        chk("rst_pre_busy", 32'(busy), 1);
        rst = 1'b1; start = 1'b1; first = 8'd1; last = 8'd5;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_terms", 32'(terms), 0);
        tick();
        chk("rst_start_dropped", 32'(busy), 0);

        chk("busy_done_exclusive", 32'(excl_viol), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
